// File: rtl/toothless_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
package toothless_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} arb_owner_t;

   // Bits needed to count 0..limit inclusive.
   function automatic int unsigned starve_cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between IF and LSU with an IF starvation counter.
module mem_arb_prio
   import toothless_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en_i,
   input  logic if_req_i,
   input  logic lsu_req_i,
   output logic win_if_o,
   output logic win_lsu_o
);

   localparam int unsigned CntW = starve_cnt_width(STARVE_LIMIT);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic            force_if;

   always_comb begin
      force_if     = if_req_i && (starve_cnt_q == CntMax);
      win_lsu_o    = arb_en_i && lsu_req_i && !force_if;
      win_if_o     = arb_en_i && if_req_i && !win_lsu_o;
      starve_cnt_d = starve_cnt_q;
      if (win_if_o) begin
         starve_cnt_d = '0;
      end else if (win_lsu_o) begin
         // Only count LSU wins that actually held off a waiting fetch.
         if (!if_req_i) begin
            starve_cnt_d = '0;
         end else if (starve_cnt_q != CntMax) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU,
// one transaction in flight at a time.
module mem_port_arbiter
   import toothless_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH   = 32,
   parameter  int unsigned ADDR_WIDTH   = 32,
   parameter  int unsigned STARVE_LIMIT = 4,
   localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // Instruction fetch port
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   // Load/store port
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [BE_WIDTH-1:0]   lsu_be_i,
   input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
   input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
   output logic                  lsu_gnt_o,
   output logic                  lsu_rvalid_o,
   output logic [DATA_WIDTH-1:0] lsu_rdata_o,
   // Memory port
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   arb_state_t            state_q, state_d;
   arb_owner_t            owner_q, owner_d;
   logic                  we_q, we_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic arb_en;
   logic win_if, win_lsu;

   // No grant may be issued while reset is asserted, since the latch would be discarded.
   assign arb_en = (state_q == ARB_IDLE) && !rst;

   mem_arb_prio #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_prio (
      .clk       (clk),
      .rst       (rst),
      .arb_en_i  (arb_en),
      .if_req_i  (if_req_i),
      .lsu_req_i (lsu_req_i),
      .win_if_o  (win_if),
      .win_lsu_o (win_lsu)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      be_d         = be_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      if_gnt_o     = win_if;
      lsu_gnt_o    = win_lsu;
      if_rvalid_o  = 1'b0;
      if_rdata_o   = '0;
      lsu_rvalid_o = 1'b0;
      lsu_rdata_o  = '0;

      unique case (state_q)
         ARB_IDLE: begin
            if (win_lsu) begin
               owner_d = OWN_LSU;
               we_d    = lsu_we_i;
               be_d    = lsu_be_i;
               addr_d  = lsu_addr_i;
               wdata_d = lsu_wdata_i;
               state_d = ARB_REQ;
            end else if (win_if) begin
               owner_d = OWN_IF;
               we_d    = 1'b0;
               be_d    = '1;
               addr_d  = if_addr_i;
               wdata_d = '0;
               state_d = ARB_REQ;
            end
         end
         ARB_REQ: begin
            // An rvalid coincident with the grant is not a response to this request.
            if (mem_gnt_i) begin
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (mem_rvalid_i) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
               if (owner_q == OWN_IF) begin
                  if_rvalid_o = 1'b1;
                  if_rdata_o  = mem_rdata_i;
               end
               if (owner_q == OWN_LSU) begin
                  lsu_rvalid_o = 1'b1;
                  lsu_rdata_o  = mem_rdata_i;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_NONE;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_req_o   = (state_q == ARB_REQ);
   assign mem_we_o    = we_q;
   assign mem_be_o    = be_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule
